ppu_cpu_registers: RTL and testbench
====================================

// Module: ppu_cpu_registers
// PURPOSE
// CPU-side responder for the PPU register window ($2000-$2007, mirrored). Decodes the 6502 bus
// access (rw, address, write data) when the address decoder asserts chip select. Returns read data
// to the CPU, holds the PPUCTRL/PPUMASK/scroll/OAM/VRAM address state, and issues VRAM
// read/write requests over a req/ack handshake to the PPU memory side.
// PARAMETERS
// VRAM_ADDRESS_WIDTH  14   width of VRAM address register v/t; wraps modulo 2^width
// INCREMENT_LARGE     32   PPUDATA address step when o_ctrl[2]=1 (step is 1 when o_ctrl[2]=0)
// PORTS
// i_clk              in   1   clock; every event is sampled on the rising edge
// i_reset            in   1   synchronous reset, active-high
// i_cs               in   1   PPU register window selected; one access per cycle where high
// i_rw               in   1   1=CPU read, 0=CPU write
// i_address          in   3   register index (CPU address[2:0])
// i_data             in   8   CPU write data
// o_data             out  8   CPU read data (combinational from current state)
// o_ctrl             out  8   PPUCTRL ($2000)
// o_mask             out  8   PPUMASK ($2001)
// o_scroll_x         out  8   first $2005 write
// o_scroll_y         out  8   second $2005 write
// i_vblank_set       in   1   pulse: set vblank flag
// i_vblank_clear     in   1   pulse: clear vblank flag (pre-render line)
// i_sprite0_hit      in   1   level: status bit 6
// i_sprite_overflow  in   1   level: status bit 5
// o_oam_address      out  8   OAM address ($2003)
// o_oam_we           out  1   one-cycle OAM write strobe
// o_oam_wdata        out  8   OAM write data
// i_oam_rdata        in   8   OAM data at o_oam_address
// o_vram_req         out  1   VRAM request; held high until i_vram_ack
// o_vram_rw          out  1   1=read, 0=write; stable while o_vram_req
// o_vram_address     out  VRAM_ADDRESS_WIDTH  VRAM address; stable while o_vram_req
// o_vram_wdata       out  8   VRAM write data; stable while o_vram_req
// i_vram_data        in   8   VRAM read data, valid in the i_vram_ack cycle
// i_vram_ack         in   1   one-cycle completion of the current request
// o_overrun          out  1   one-cycle pulse: PPUDATA access dropped because a request is pending
// BEHAVIOUR
// - Reset: all outputs and registers 0 (ctrl, mask, scroll, oam addr, v, t, toggle w, read buffer,
//   vblank flag, open-bus latch); FSM=IDLE. Reset mid-request drops it; o_vram_req low next cycle.
// - Side effects commit on the rising edge at the end of an i_cs cycle; o_data reflects pre-edge state.
// - Every write (any index) loads the open-bus latch with i_data.
// - Reads: idx2 = {vblank, i_sprite0_hit, i_sprite_overflow, latch[4:0]}; idx4 = i_oam_rdata;
//   idx7 = read buffer; idx0,1,3,5,6 = open-bus latch. o_data = 0 when i_cs low.
// - Read idx2: clears vblank flag and w. Simultaneous i_vblank_set: set wins (read returns 0, flag=1).
//   i_vblank_set and i_vblank_clear together: clear wins.
// - Write idx0 -> o_ctrl; idx1 -> o_mask; idx3 -> o_oam_address.
// - Write idx4: o_oam_we=1 next cycle with o_oam_wdata=i_data at old address; o_oam_address += 1
//   (wraps $FF->$00).
// - Write idx5: w=0 -> scroll_x, w=1 -> scroll_y; w toggles.
// - Write idx6: w=0 -> t[13:8]=i_data[5:0], t[14+]=0; w=1 -> t[7:0]=i_data, v=t; w toggles.
//   w is shared between idx5 and idx6.
// - FSM IDLE/BUSY. PPUDATA (idx7) access in IDLE: latch address=v, rw, wdata. Enter BUSY with
//   o_vram_req=1 next cycle. v += step, wrapping modulo 2^VRAM_ADDRESS_WIDTH.
// - BUSY: on i_vram_ack -> IDLE, req low next cycle; a read loads the buffer with i_vram_data.
//   The CPU sees the new buffer only on the next idx7 read (one-read latency).
// - PPUDATA access while BUSY: no v change, no request, o_overrun pulse; a read still returns
//   the buffer. Ack in the same cycle as a new PPUDATA access: ack completes, access dropped.
// - i_vram_ack in IDLE is ignored. Palette range gets no special read handling.
// TESTING
// - Reset, then read idx2 with no events -> o_data=$00; all outputs 0, o_vram_req=0.
// - Write idx6 $21, $08; write idx7 $AB -> req rw=0 addr $2108 wdata $AB; ack -> v=$2109.
// - ctrl[2]=1, v=$3FF0: read idx7 twice, ack each -> addrs $3FF0, $0010; 2nd read returns 1st ack data.
// - i_vblank_set; read idx2 -> $80|bits; next read $00; vblank_set with read -> $00, then $80.
// - Write idx5 $10 then read idx2 then write idx5 $20 -> scroll_x=$20, scroll_y unchanged.
// - Write idx3 $FF, idx4 $5A, idx4 $5B -> oam_we at $FF then $00; idx7 while BUSY -> o_overrun.

Source files
------------

// File: rtl/ppu_cpu_registers.sv
// CPU-facing PPU register window: decodes $2000-$2007 accesses, holds ctrl/mask/scroll/OAM/VRAM
// address state; PPUDATA accesses become one outstanding VRAM request (req/ack), extras are dropped.
module ppu_cpu_registers #(
  parameter int VRAM_ADDRESS_WIDTH = 14,
  parameter int INCREMENT_LARGE    = 32
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_cs,
  input  logic                          i_rw,
  input  logic [2:0]                    i_address,
  input  logic [7:0]                    i_data,
  output logic [7:0]                    o_data,
  output logic [7:0]                    o_ctrl,
  output logic [7:0]                    o_mask,
  output logic [7:0]                    o_scroll_x,
  output logic [7:0]                    o_scroll_y,
  input  logic                          i_vblank_set,
  input  logic                          i_vblank_clear,
  input  logic                          i_sprite0_hit,
  input  logic                          i_sprite_overflow,
  output logic [7:0]                    o_oam_address,
  output logic                          o_oam_we,
  output logic [7:0]                    o_oam_wdata,
  input  logic [7:0]                    i_oam_rdata,
  output logic                          o_vram_req,
  output logic                          o_vram_rw,
  output logic [VRAM_ADDRESS_WIDTH-1:0] o_vram_address,
  output logic [7:0]                    o_vram_wdata,
  input  logic [7:0]                    i_vram_data,
  input  logic                          i_vram_ack,
  output logic                          o_overrun
);
  localparam int VW = VRAM_ADDRESS_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q;
  logic [7:0]      ctrl_q, mask_q, scroll_x_q, scroll_y_q;
  logic [7:0]      oam_addr_q, oam_wdata_q, latch_q, rbuf_q;
  logic            oam_we_q, vblank_q, w_q, overrun_q;
  logic [VW-1:0]   v_q, t_q;
  logic            vram_rw_q;
  logic [VW-1:0]   vram_addr_q;
  logic [7:0]      vram_wdata_q;

  logic            wr_en, rd_status, acc_data;
  logic [VW-1:0]   v_inc_d, t_hi_d, t_lo_d;

  assign wr_en     = i_cs & ~i_rw;
  assign rd_status = i_cs & i_rw & (i_address == 3'd2);
  assign acc_data  = i_cs & (i_address == 3'd7);

  // High half of t keeps only 6 bits; anything above bit 13 is forced to zero.
  assign t_hi_d  = VW'({2'b00, i_data[5:0], t_q[7:0]});
  assign t_lo_d  = {t_q[VW-1:8], i_data};
  assign v_inc_d = v_q + (ctrl_q[2] ? VW'(INCREMENT_LARGE) : VW'(1));

  always_comb begin
    o_data = '0;
    if (i_cs) begin
      case (i_address)
        3'd2:    o_data = {vblank_q, i_sprite0_hit, i_sprite_overflow, latch_q[4:0]};
        3'd4:    o_data = i_oam_rdata;
        3'd7:    o_data = rbuf_q;
        default: o_data = latch_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      ctrl_q       <= '0;
      mask_q       <= '0;
      scroll_x_q   <= '0;
      scroll_y_q   <= '0;
      oam_addr_q   <= '0;
      oam_wdata_q  <= '0;
      oam_we_q     <= 1'b0;
      latch_q      <= '0;
      rbuf_q       <= '0;
      vblank_q     <= 1'b0;
      w_q          <= 1'b0;
      overrun_q    <= 1'b0;
      v_q          <= '0;
      t_q          <= '0;
      vram_rw_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_wdata_q <= '0;
    end else begin
      oam_we_q  <= 1'b0;
      overrun_q <= 1'b0;

      // OAM pointer advances after the strobe so the strobe cycle shows the slot written.
      if (oam_we_q) oam_addr_q <= oam_addr_q + 8'd1;

      if (i_vblank_clear)    vblank_q <= 1'b0;
      else if (i_vblank_set) vblank_q <= 1'b1;
      else if (rd_status)    vblank_q <= 1'b0;

      if (rd_status) w_q <= 1'b0;

      if (wr_en) begin
        latch_q <= i_data;
        case (i_address)
          3'd0: ctrl_q     <= i_data;
          3'd1: mask_q     <= i_data;
          3'd3: oam_addr_q <= i_data;
          3'd4: begin
            oam_we_q    <= 1'b1;
            oam_wdata_q <= i_data;
          end
          3'd5: begin
            if (!w_q) scroll_x_q <= i_data;
            else      scroll_y_q <= i_data;
            w_q <= ~w_q;
          end
          3'd6: begin
            if (!w_q) begin
              t_q <= t_hi_d;
            end else begin
              t_q <= t_lo_d;
              v_q <= t_lo_d;
            end
            w_q <= ~w_q;
          end
          default: ;
        endcase
      end

      case (state_q)
        IDLE: begin
          if (acc_data) begin
            state_q      <= BUSY;
            vram_rw_q    <= i_rw;
            vram_addr_q  <= v_q;
            vram_wdata_q <= i_data;
            v_q          <= v_inc_d;
          end
        end
        BUSY: begin
          if (acc_data) overrun_q <= 1'b1;
          if (i_vram_ack) begin
            state_q <= IDLE;
            if (vram_rw_q) rbuf_q <= i_vram_data;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ctrl         = ctrl_q;
  assign o_mask         = mask_q;
  assign o_scroll_x     = scroll_x_q;
  assign o_scroll_y     = scroll_y_q;
  assign o_oam_address  = oam_addr_q;
  assign o_oam_we       = oam_we_q;
  assign o_oam_wdata    = oam_wdata_q;
  assign o_vram_req     = (state_q == BUSY);
  assign o_vram_rw      = vram_rw_q;
  assign o_vram_address = vram_addr_q;
  assign o_vram_wdata   = vram_wdata_q;
  assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_ppu_cpu_registers.sv
// Bench for ppu_cpu_registers: directed scenarios plus a random run against a register-level model.
module tb_ppu_cpu_registers;
  logic        i_clk = 1'b0;
  logic        i_reset, i_cs, i_rw;
  logic [2:0]  i_address;
  logic [7:0]  i_data, o_data, o_ctrl, o_mask, o_scroll_x, o_scroll_y;
  logic        i_vblank_set, i_vblank_clear, i_sprite0_hit, i_sprite_overflow;
  logic [7:0]  o_oam_address, o_oam_wdata, i_oam_rdata;
  logic        o_oam_we, o_vram_req, o_vram_rw, i_vram_ack, o_overrun;
  logic [13:0] o_vram_address;
  logic [7:0]  o_vram_wdata, i_vram_data;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural PPU register state.
  logic [7:0] m_ctrl, m_mask, m_sx, m_sy, m_latch, m_buf, m_oam_ptr, m_we_addr, m_we_data, m_req_wd;
  logic       m_w, m_vbl, m_busy, m_req_rw, m_ov_exp, m_we_exp;
  int         m_v, m_t, m_req_addr;

  always #5 i_clk = ~i_clk;

  ppu_cpu_registers #(.VRAM_ADDRESS_WIDTH(14), .INCREMENT_LARGE(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cs(i_cs), .i_rw(i_rw), .i_address(i_address),
    .i_data(i_data), .o_data(o_data), .o_ctrl(o_ctrl), .o_mask(o_mask),
    .o_scroll_x(o_scroll_x), .o_scroll_y(o_scroll_y), .i_vblank_set(i_vblank_set),
    .i_vblank_clear(i_vblank_clear), .i_sprite0_hit(i_sprite0_hit),
    .i_sprite_overflow(i_sprite_overflow), .o_oam_address(o_oam_address), .o_oam_we(o_oam_we),
    .o_oam_wdata(o_oam_wdata), .i_oam_rdata(i_oam_rdata), .o_vram_req(o_vram_req),
    .o_vram_rw(o_vram_rw), .o_vram_address(o_vram_address), .o_vram_wdata(o_vram_wdata),
    .i_vram_data(i_vram_data), .i_vram_ack(i_vram_ack), .o_overrun(o_overrun)
  );

  task automatic model_reset();
    m_ctrl = 0; m_mask = 0; m_sx = 0; m_sy = 0; m_latch = 0; m_buf = 0; m_oam_ptr = 0;
    m_we_addr = 0; m_we_data = 0; m_req_wd = 0; m_w = 0; m_vbl = 0; m_busy = 0;
    m_req_rw = 0; m_ov_exp = 0; m_we_exp = 0; m_v = 0; m_t = 0; m_req_addr = 0;
  endtask

  // Drives one bus cycle, samples o_data before the edge and advances the model.
  task automatic step(input logic cs, input logic rw, input logic [2:0] a, input logic [7:0] d,
                      input logic vset, input logic vclr, input logic ack, input logic [7:0] adata,
                      output logic [7:0] got, output logic [7:0] want);
    logic was_busy;
    i_cs = cs; i_rw = rw; i_address = a; i_data = d;
    i_vblank_set = vset; i_vblank_clear = vclr; i_vram_ack = ack; i_vram_data = adata;
    i_oam_rdata = 8'($urandom);
    #1;
    got = o_data;
    if (!cs) want = 8'h00;
    else case (a)
      3'd2:    want = {m_vbl, i_sprite0_hit, i_sprite_overflow, m_latch[4:0]};
      3'd4:    want = i_oam_rdata;
      3'd7:    want = m_buf;
      default: want = m_latch;
    endcase
    was_busy = m_busy;
    m_ov_exp = 0;
    m_we_exp = 0;
    if (was_busy && ack) begin
      if (m_req_rw) m_buf = adata;
      m_busy = 0;
    end
    if (cs && a == 3'd7) begin
      if (was_busy) m_ov_exp = 1;
      else begin
        m_busy = 1; m_req_rw = rw; m_req_addr = m_v; m_req_wd = d;
        m_v = (m_v + (m_ctrl[2] ? 32 : 1)) % 16384;
      end
    end
    if (vclr) m_vbl = 0;
    else if (vset) m_vbl = 1;
    else if (cs && rw && a == 3'd2) m_vbl = 0;
    if (cs && rw && a == 3'd2) m_w = 0;
    if (cs && !rw) begin
      m_latch = d;
      case (a)
        3'd0: m_ctrl = d;
        3'd1: m_mask = d;
        3'd3: m_oam_ptr = d;
        3'd4: begin m_we_exp = 1; m_we_addr = m_oam_ptr; m_we_data = d; m_oam_ptr = m_oam_ptr + 8'd1; end
        3'd5: begin if (!m_w) m_sx = d; else m_sy = d; m_w = !m_w; end
        3'd6: begin
          if (!m_w) m_t = ((d & 8'h3F) << 8) | (m_t & 'hFF);
          else begin m_t = (m_t & 'h3F00) | d; m_v = m_t; end
          m_w = !m_w;
        end
        default: ;
      endcase
    end
    @(posedge i_clk);
    #1;
    i_cs = 0; i_vblank_set = 0; i_vblank_clear = 0; i_vram_ack = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] g, w;
    step(1'b1, 1'b0, a, d, 1'b0, 1'b0, 1'b0, 8'h00, g, w);
  endtask

  task automatic ack(input logic [7:0] adata);
    logic [7:0] g, w;
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, adata, g, w);
  endtask

  task automatic test_reset();
    logic [7:0] g, w;
    i_reset = 1;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 0;
    model_reset();
    total++;
    if ({o_ctrl, o_mask, o_scroll_x, o_scroll_y, o_oam_address, o_oam_wdata, o_data} !== 56'h0) begin
      bad++; $display("FAIL reset_regs got=%h want=0", {o_ctrl, o_mask, o_scroll_x, o_scroll_y, o_oam_address, o_oam_wdata, o_data});
    end
    total++;
    if ({o_oam_we, o_vram_req, o_overrun} !== 3'b000) begin
      bad++; $display("FAIL reset_strobes got=%b want=000", {o_oam_we, o_vram_req, o_overrun});
    end
    step(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g, w);
    total++;
    if (g !== 8'h00) begin bad++; $display("FAIL reset_status got=%h want=00", g); end
  endtask

  task automatic test_ppudata_write();
    logic [7:0] g, w;
    wr(3'd6, 8'h21);
    wr(3'd6, 8'h08);
    wr(3'd7, 8'hAB);
    total++;
    if ({o_vram_req, o_vram_rw, o_vram_address, o_vram_wdata} !== {1'b1, 1'b0, 14'h2108, 8'hAB}) begin
      bad++; $display("FAIL write_req got=%b/%b/%h/%h want=1/0/2108/ab", o_vram_req, o_vram_rw, o_vram_address, o_vram_wdata);
    end
    ack(8'h00);
    total++;
    if (o_vram_req !== 1'b0) begin bad++; $display("FAIL write_ack_req got=%b want=0", o_vram_req); end
    step(1'b1, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g, w);
    total++;
    if (o_vram_address !== 14'h2109 || o_vram_rw !== 1'b1) begin
      bad++; $display("FAIL write_vinc got=%h/%b want=2109/1", o_vram_address, o_vram_rw);
    end
    ack(8'h5C);
  endtask

  task automatic test_increment_wrap();
    logic [7:0] g, w;
    wr(3'd0, 8'h04);
    wr(3'd6, 8'h3F);
    wr(3'd6, 8'hF0);
    step(1'b1, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g, w);
    total++;
    if (o_vram_address !== 14'h3FF0) begin bad++; $display("FAIL wrap_addr1 got=%h want=3ff0", o_vram_address); end
    ack(8'h11);
    step(1'b1, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g, w);
    total++;
    if (g !== 8'h11) begin bad++; $display("FAIL wrap_rdata got=%h want=11", g); end
    total++;
    if (o_vram_address !== 14'h0010) begin bad++; $display("FAIL wrap_addr2 got=%h want=0010", o_vram_address); end
    ack(8'h22);
    step(1'b1, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g, w);
    total++;
    if (g !== 8'h22) begin bad++; $display("FAIL wrap_rdata2 got=%h want=22", g); end
    ack(8'h00);
    wr(3'd0, 8'h00);
  endtask

  task automatic test_vblank();
    logic [7:0] g, w;
    i_sprite0_hit = 1; i_sprite_overflow = 0;
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, g, w);
    step(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g, w);
    total++;
    if (g !== w || g[7] !== 1'b1) begin bad++; $display("FAIL vbl_set got=%h want=%h", g, w); end
    i_sprite0_hit = 0;
    step(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g, w);
    total++;
    if (g !== {3'b000, m_latch[4:0]}) begin bad++; $display("FAIL vbl_cleared got=%h want=%h", g, {3'b000, m_latch[4:0]}); end
    step(1'b1, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, g, w);
    total++;
    if (g[7] !== 1'b0) begin bad++; $display("FAIL vbl_race_read got=%h want=bit7 0", g); end
    step(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g, w);
    total++;
    if (g[7] !== 1'b1) begin bad++; $display("FAIL vbl_race_after got=%h want=bit7 1", g); end
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, g, w);
    step(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g, w);
    total++;
    if (g[7] !== 1'b0) begin bad++; $display("FAIL vbl_clear_wins got=%h want=bit7 0", g); end
  endtask

  task automatic test_scroll();
    logic [7:0] g, w, sy_before;
    sy_before = o_scroll_y;
    wr(3'd5, 8'h10);
    step(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g, w);
    wr(3'd5, 8'h20);
    total++;
    if (o_scroll_x !== 8'h20 || o_scroll_y !== sy_before) begin
      bad++; $display("FAIL scroll_toggle got=%h/%h want=20/%h", o_scroll_x, o_scroll_y, sy_before);
    end
  endtask

  task automatic test_oam();
    wr(3'd3, 8'hFF);
    wr(3'd4, 8'h5A);
    total++;
    if ({o_oam_we, o_oam_address, o_oam_wdata} !== {1'b1, 8'hFF, 8'h5A}) begin
      bad++; $display("FAIL oam_first got=%b/%h/%h want=1/ff/5a", o_oam_we, o_oam_address, o_oam_wdata);
    end
    wr(3'd4, 8'h5B);
    total++;
    if ({o_oam_we, o_oam_address, o_oam_wdata} !== {1'b1, 8'h00, 8'h5B}) begin
      bad++; $display("FAIL oam_wrap got=%b/%h/%h want=1/00/5b", o_oam_we, o_oam_address, o_oam_wdata);
    end
    ack(8'h00);
    total++;
    if (o_oam_we !== 1'b0 || o_oam_address !== 8'h01) begin
      bad++; $display("FAIL oam_after got=%b/%h want=0/01", o_oam_we, o_oam_address);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] g, w;
    int v_before;
    v_before = m_v;
    wr(3'd7, 8'h33);
    step(1'b1, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g, w);
    total++;
    if (o_overrun !== 1'b1 || o_vram_address !== 14'(v_before) || g !== w) begin
      bad++; $display("FAIL overrun_busy got=%b/%h/%h want=1/%h/%h", o_overrun, o_vram_address, g, 14'(v_before), w);
    end
    step(1'b1, 1'b0, 3'd7, 8'h44, 1'b0, 1'b0, 1'b1, 8'h00, g, w);
    total++;
    if (o_overrun !== 1'b1 || o_vram_req !== 1'b0) begin
      bad++; $display("FAIL overrun_ack_race got=%b/%b want=1/0", o_overrun, o_vram_req);
    end
    wr(3'd7, 8'h55);
    total++;
    if (o_vram_address !== 14'((v_before + 1) % 16384) || o_overrun !== 1'b0) begin
      bad++; $display("FAIL overrun_vhold got=%h/%b want=%h/0", o_vram_address, o_overrun, 14'((v_before + 1) % 16384));
    end
    i_reset = 1;
    @(posedge i_clk);
    #1;
    i_reset = 0;
    model_reset();
    total++;
    if (o_vram_req !== 1'b0) begin bad++; $display("FAIL reset_mid_req got=%b want=0", o_vram_req); end
  endtask

  task automatic test_random();
    logic [7:0] g, w;
    logic       cs, rw, vs, vc, ak;
    logic [2:0] a;
    for (int n = 0; n < 800; n++) begin
      cs = ($urandom % 4) != 0;
      rw = $urandom % 2;
      a  = ($urandom % 3 == 0) ? 3'd7 : 3'($urandom);
      vs = ($urandom % 16) == 0;
      vc = ($urandom % 32) == 0;
      ak = m_busy ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
      i_sprite0_hit = $urandom % 2;
      i_sprite_overflow = $urandom % 2;
      step(cs, rw, a, 8'($urandom), vs, vc, ak, 8'($urandom), g, w);
      total++;
      if (g !== w) begin bad++; $display("FAIL rnd_rdata n=%0d a=%0d got=%h want=%h", n, a, g, w); end
      total++;
      if ({o_ctrl, o_mask, o_scroll_x, o_scroll_y} !== {m_ctrl, m_mask, m_sx, m_sy}) begin
        bad++; $display("FAIL rnd_regs n=%0d got=%h want=%h", n, {o_ctrl, o_mask, o_scroll_x, o_scroll_y}, {m_ctrl, m_mask, m_sx, m_sy});
      end
      total++;
      if (o_vram_req !== m_busy || o_overrun !== m_ov_exp) begin
        bad++; $display("FAIL rnd_req n=%0d got=%b/%b want=%b/%b", n, o_vram_req, o_overrun, m_busy, m_ov_exp);
      end
      if (m_busy) begin
        total++;
        if (o_vram_address !== 14'(m_req_addr) || o_vram_rw !== m_req_rw || (!m_req_rw && o_vram_wdata !== m_req_wd)) begin
          bad++; $display("FAIL rnd_reqdat n=%0d got=%h/%b/%h want=%h/%b/%h", n, o_vram_address, o_vram_rw, o_vram_wdata, 14'(m_req_addr), m_req_rw, m_req_wd);
        end
      end
      total++;
      if (o_oam_we !== m_we_exp || o_oam_address !== (m_we_exp ? m_we_addr : m_oam_ptr) || (m_we_exp && o_oam_wdata !== m_we_data)) begin
        bad++; $display("FAIL rnd_oam n=%0d got=%b/%h/%h want=%b/%h/%h", n, o_oam_we, o_oam_address, o_oam_wdata, m_we_exp, m_we_exp ? m_we_addr : m_oam_ptr, m_we_data);
      end
    end
  endtask

  initial begin
    i_reset = 1; i_cs = 0; i_rw = 0; i_address = 0; i_data = 0;
    i_vblank_set = 0; i_vblank_clear = 0; i_sprite0_hit = 0; i_sprite_overflow = 0;
    i_oam_rdata = 0; i_vram_ack = 0; i_vram_data = 0;
    model_reset();
    test_reset();
    test_ppudata_write();
    test_increment_wrap();
    test_vblank();
    test_scroll();
    test_oam();
    test_overrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
